// File: rtl/mdu_pkg.sv
// Shared decode constants and FSM state type for the multiply/divide unit.
package mdu_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  function automatic logic is_mdu_funct(input logic [5:0] f);
    return f inside {FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
                     FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the datapath: shift-add multiply or restoring shift-subtract
// divide on a {upper, lower} 2*WIDTH accumulator of operand magnitudes.
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_trial;

  // Multiply: lower half holds the remaining multiplier bits, consumed from bit 0.
  assign w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
  // Divide: partial remainder shifted left by one, then compared against the divisor.
  assign w_trial = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_opnd};

  // NOTE: o_acc is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    o_acc = {w_sum, i_acc[WIDTH-1:1]};
    if (i_is_div) begin
      if (!w_trial[WIDTH]) o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      else                 o_acc = {i_acc[2*WIDTH-2:WIDTH-1], i_acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit with IDLE/ITER/FIX control.
// Define MDU_FAST_MUL_EN to compute mult/multu with a single-cycle multiplier.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e r_state, w_next;

  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_a;
  logic               r_is_div, r_neg_a, r_neg_b, r_div_zero;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done;

  logic               w_rtype, w_is_mult, w_is_div, w_is_signed, w_accept;
  logic               w_neg_a, w_neg_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0] w_step;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

  assign w_rtype     = (alu_op == ALUOP_RTYPE);
  assign w_is_mult   = w_rtype && (funct == FUNCT_MULT || funct == FUNCT_MULTU);
  assign w_is_div    = w_rtype && (funct == FUNCT_DIV  || funct == FUNCT_DIVU);
  assign w_is_signed = ~funct[0];
  assign w_accept    = start && (r_state == IDLE) && (w_is_mult || w_is_div);

  assign w_neg_a = w_is_signed & a[WIDTH-1];
  assign w_neg_b = w_is_signed & b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -a : a;
  assign w_mag_b = w_neg_b ? -b : b;

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) begin
`ifdef MDU_FAST_MUL_EN
        w_next = w_is_mult ? FIX : ITER;
`else
        w_next = ITER;
`endif
      end
      ITER:    if (r_cnt == '0) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Sign correction; a zero divisor bypasses it and reports LO=all ones, HI=a.
  always_comb begin
    {w_fix_hi, w_fix_lo} = r_acc;
    if (!r_is_div) begin
      if (r_neg_a ^ r_neg_b) {w_fix_hi, w_fix_lo} = -r_acc;
    end else if (r_div_zero) begin
      w_fix_hi = r_a;
      w_fix_lo = '1;
    end else begin
      if (r_neg_a ^ r_neg_b) w_fix_lo = -r_acc[WIDTH-1:0];
      if (r_neg_a)           w_fix_hi = -r_acc[2*WIDTH-1:WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values. The datapath registers are reset too, keeping the unit
  // fully deterministic after an abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_a        <= '0;
      r_is_div   <= 1'b0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt      <= CW'(WIDTH - 1);
            r_is_div   <= w_is_div;
            r_neg_a    <= w_neg_a;
            r_neg_b    <= w_neg_b;
            r_a        <= a;
            r_div_zero <= (b == '0);
            r_opnd     <= w_is_div ? w_mag_b : w_mag_a;
            r_acc      <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
`ifdef MDU_FAST_MUL_EN
            if (w_is_mult) r_acc <= {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`endif
          end else if (start && w_rtype && funct == FUNCT_MTHI) begin
            r_hi <= a;
          end else if (start && w_rtype && funct == FUNCT_MTLO) begin
            r_lo <= a;
          end
        end
        ITER: begin
          r_acc <= w_step;
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state == ITER) || (r_state == FIX);
  assign stall = start && w_rtype && is_mdu_funct(funct) && busy;
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

  always_comb begin
    result = '0;
    if      (funct == FUNCT_MFHI) result = r_hi;
    else if (funct == FUNCT_MFLO) result = r_lo;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at WIDTH=32.
// Honours MDU_FAST_MUL_EN when the design is built with it.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic         clk, reset, start;
  logic [5:0]   funct;
  logic [1:0]   alu_op;
  logic [W-1:0] a, b;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo, result;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct  (funct),
    .alu_op (alu_op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi     (hi),
    .lo     (lo),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [1:0] op, input logic [5:0] f,
                       input logic [W-1:0] av, input logic [W-1:0] bv);
    start  = s;
    alu_op = op;
    funct  = f;
    a      = av;
    b      = bv;
  endtask

  // Issue one op, scramble operands after acceptance, then check latency and HI/LO.
  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input int exp_lat);
    int cyc;
    cyc = 0;
    drive(1'b1, ALUOP_RTYPE, f, av, bv);
    tick();
    drive(1'b0, ALUOP_RTYPE, 6'b000000, ~av, ~bv);
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
    check({tag, "_busy_cycles"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int cyc;
    int stall_bad;
    int done_seen;

    reset = 1'b1;
    drive(1'b0, 2'b00, 6'b000000, '0, '0);
    tick();
    tick();
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    #2 reset = 1'b0;
    tick();

    run_op("mult_neg",  FUNCT_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT);
    run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
    run_op("divu_17_5", FUNCT_DIVU,  32'd17,        32'd5,        32'd2,         32'd3,         DIV_LAT);
    run_op("div_m17_5", FUNCT_DIV,   32'hFFFF_FFEF, 32'd5,        32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
    run_op("divu_by0",  FUNCT_DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, DIV_LAT);
    run_op("div_by0",   FUNCT_DIV,   32'hFFFF_FFF8, 32'd0,        32'hFFFF_FFF8, 32'hFFFF_FFFF, DIV_LAT);
    run_op("div_ovf",   FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, DIV_LAT);
`ifdef MDU_FAST_MUL_EN
    run_op("fast_mult", FUNCT_MULT,  32'd7,         32'd6,        32'd0,         32'd42,        1);
`endif

    // mthi / mtlo and combinational mfhi / mflo reads
    drive(1'b1, ALUOP_RTYPE, FUNCT_MTHI, 32'h1234_5678, 32'd0);
    tick();
    drive(1'b1, ALUOP_RTYPE, FUNCT_MTLO, 32'h9ABC_DEF0, 32'd0);
    tick();
    drive(1'b0, ALUOP_RTYPE, FUNCT_MFHI, 32'd0, 32'd0);
    #1 check("mthi_result", 64'(result), 64'h1234_5678);
    funct = FUNCT_MFLO;
    #1 check("mtlo_result", 64'(result), 64'h9ABC_DEF0);
    funct = 6'b100000;
    #1 check("other_result", 64'(result), 64'd0);

    // Ignored requests: wrong alu_op, unknown funct
    drive(1'b1, 2'b00, FUNCT_MULT, 32'd3, 32'd3);
    tick();
    check("aluop_ignored", 64'(busy), 64'd0);
    drive(1'b1, ALUOP_RTYPE, 6'b100000, 32'd3, 32'd3);
    tick();
    check("funct_ignored", 64'(busy), 64'd0);
    check("funct_ignored_hi", 64'(hi), 64'h1234_5678);

    // mfhi held while busy: stall every busy cycle, then read new HI
    drive(1'b1, ALUOP_RTYPE, FUNCT_DIVU, 32'hFFFF_FFFF, 32'h0000_0010);
    tick();
    drive(1'b1, ALUOP_RTYPE, FUNCT_MFHI, 32'd0, 32'd0);
    cyc = 0;
    stall_bad = 0;
    while (busy === 1'b1 && cyc < 100) begin
      if (stall !== 1'b1) stall_bad++;
      cyc++;
      tick();
    end
    check("stall_cycles_bad", 64'(stall_bad), 64'd0);
    check("stall_busy_cycles", 64'(cyc), 64'(DIV_LAT));
    check("stall_released", 64'(stall), 64'd0);
    check("stall_mfhi_result", 64'(result), 64'h0000_000F);
    check("stall_lo", 64'(lo), 64'h0FFF_FFFF);
    drive(1'b0, ALUOP_RTYPE, 6'b000000, 32'd0, 32'd0);
    tick();

    // Second mult issued while busy is ignored
    drive(1'b1, ALUOP_RTYPE, FUNCT_MULT, 32'd2, 32'd3);
    tick();
    drive(1'b1, ALUOP_RTYPE, FUNCT_MULT, 32'd100, 32'd100);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
    drive(1'b0, ALUOP_RTYPE, 6'b000000, 32'd0, 32'd0);
    check("second_busy_cycles", 64'(cyc), 64'(MUL_LAT));
    check("second_hi", 64'(hi), 64'd0);
    check("second_lo", 64'(lo), 64'd6);
    tick();
    check("second_not_queued", 64'(busy), 64'd0);

    // Reset in ITER cycle 10 aborts; stall stays low for non-MDU requests
    drive(1'b1, ALUOP_RTYPE, FUNCT_DIVU, 32'd100, 32'd7);
    tick();
    drive(1'b1, ALUOP_RTYPE, 6'b100000, 32'd0, 32'd0);
    #1 check("stall_other_funct", 64'(stall), 64'd0);
    alu_op = 2'b00;
    funct  = FUNCT_MULT;
    #1 check("stall_other_aluop", 64'(stall), 64'd0);
    drive(1'b0, ALUOP_RTYPE, 6'b000000, 32'd0, 32'd0);
    for (int i = 0; i < 9; i++) tick();
    check("pre_abort_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    tick();
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) done_seen++;
      tick();
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_hi_after", 64'(hi), 64'd0);
    check("abort_lo_after", 64'(lo), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, giving the operand, HI, LO and result width (legal range 8..64).
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  asynchronous active-high reset.
REQ-003 SHALL have ports: start  input  1  request valid this cycle.
REQ-004 funct  input  6  R-type function field.
REQ-005 alu_op  input  2  main-decoder ALU op; only 2'b10 (R-type) enables the unit.
REQ-006 a, b  input  WIDTH each  rs and rt operands.
REQ-007 busy  output  1  multiply/divide in progress.
REQ-008 stall  output  1  pipeline hold request.
REQ-009 done  output  1  one-cycle pulse, HI/LO just updated.
REQ-010 hi, lo  output  WIDTH each  architectural HI/LO registers.
REQ-011 result  output  WIDTH  mfhi/mflo read data.

Function
REQ-012 SHALL recognise, when alu_op=2'b10, these funct values: mfhi 010000, mthi 010001, mflo 010010, mtlo 010011, mult 011000, multu 011001, div 011010, divu 011011; all other funct/alu_op combinations are ignored.
REQ-013 SHALL use states IDLE, ITER and FIX.
REQ-014 A mult/multu/div/divu is accepted on an edge where state=IDLE and start=1; transition IDLE->ITER with a cycle counter loaded to WIDTH-1.
REQ-015 ITER SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on operand magnitudes for exactly WIDTH cycles, then go to FIX.
REQ-016 FIX SHALL apply sign correction (signed ops: product negated if sign(a)!=sign(b); quotient negated if sign(a)!=sign(b); remainder takes sign of a), write HI/LO on the edge leaving FIX, and return to IDLE.
REQ-017 done SHALL be registered and high for exactly the one cycle after the HI/LO write; busy SHALL be 1 exactly while state is ITER or FIX.
REQ-018 Accept-to-HI/LO-write latency SHALL be WIDTH+1 edges.
REQ-019 Multiply results SHALL be the full 2*WIDTH product, with upper half in HI and lower half in LO.
REQ-020 Divide results SHALL place the quotient in LO and the remainder in HI; -2^(WIDTH-1)/-1 SHALL give LO=-2^(WIDTH-1), HI=0.
REQ-021 On divide by zero (signed or unsigned), LO SHALL be all ones and HI SHALL equal a, with sign correction suppressed; latency is unchanged.
REQ-022 mthi/mtlo SHALL write a into HI/LO at the next edge when state=IDLE.
REQ-023 result SHALL be combinational: hi when funct=mfhi, lo when funct=mflo, else 0.
REQ-024 stall SHALL be combinational: 1 when start=1, alu_op=2'b10, any REQ-012 funct is present, and busy=1; 0 otherwise.
REQ-025 Requests made while busy SHALL be ignored (not queued); operands SHALL be captured at acceptance, so later changes to a/b have no effect.

Reset
REQ-026 Reset SHALL force state=IDLE, hi=0, lo=0, done=0, busy=0 and counter=0, asynchronously.
REQ-027 Reset mid-operation SHALL abort the operation with no HI/LO write and no done pulse.

Configuration
REQ-028 Macro MDU_FAST_MUL_EN: when defined, mult/multu SHALL skip ITER (IDLE->FIX) and compute the product with a single-cycle multiplier, giving a latency of 1 edge.
REQ-029 When MDU_FAST_MUL_EN is undefined, multiply SHALL be iterative per REQ-015; divide SHALL be iterative in both builds.

Structure
REQ-030 Package mdu_pkg SHALL hold the funct localparams, the ALUOP_RTYPE constant and the state enum type.
REQ-031 The per-cycle shift-add/shift-subtract datapath SHALL be a sub-module named mdu_iter_step; control and HI/LO registers SHALL stay in mul_div_unit.

Verification (WIDTH=32, macro undefined unless stated)
REQ-032 mult a=-3 (FFFFFFFD), b=5 -> after 33 edges HI=FFFFFFFF, LO=FFFFFFF1, one done pulse, busy high for 33 cycles.
REQ-033 divu 17/5 -> LO=3, HI=2; div -17/5 -> LO=FFFFFFFD, HI=FFFFFFFE.
REQ-034 divu 7/0 -> LO=FFFFFFFF, HI=7; div 80000000/FFFFFFFF -> LO=80000000, HI=0.
REQ-035 mfhi asserted during ITER -> stall=1 each cycle until busy falls, then result equals new HI; second mult issued while busy -> ignored, HI/LO reflect the first op only.
REQ-036 reset pulsed at ITER cycle 10 -> hi=lo=0, no done; with MDU_FAST_MUL_EN, mult 7*6 -> LO=42 (0x2A), HI=0 one edge after accept.
